// File: rtl/mips_muldiv_pkg.sv
// Shared ALU-control function codes and the multiply/divide FSM state type.
// Also provides the decode helper for HI/LO unit function codes.
package mips_muldiv_pkg;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

    function automatic logic is_muldiv_fn(input logic [5:0] fn);
        case (fn)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_muldiv_datapath.sv
// Iteration registers for the multi-cycle unit: one shift-add multiply step
// or one restoring-division step per cycle, plus the iteration counter.
module mips_muldiv_datapath
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   init_acc,
    input  logic [WIDTH:0]       init_opnd,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH:0]     opnd_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;

    // Next accumulator: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? opnd_r : {(WIDTH+1){1'b0}});
        shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
        ge_s      = (shifted_s >= opnd_r);
        // True difference is below 2^WIDTH whenever ge_s holds, so the low bits are exact.
        diff_s    = shifted_s[WIDTH-1:0] - opnd_r[WIDTH-1:0];
        acc_nxt_s = acc_r;
        if (div_mode) begin
            if (ge_s) begin
                acc_nxt_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Iteration registers: load on acceptance, advance one bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {(2*WIDTH){1'b0}};
            opnd_r <= {(WIDTH+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else if (load) begin
            acc_r  <= init_acc;
            opnd_r <= init_opnd;
            cnt_r  <= {CW{1'b0}};
        end else if (step) begin
            acc_r  <= acc_nxt_s;
            cnt_r  <= cnt_r + CW'(1);
        end
    end

    assign acc  = acc_r;
    assign last = (cnt_r == CW'(WIDTH-1));

endmodule

// File: rtl/mips_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Control FSM, sign handling and HI/LO live here; iteration is in the datapath.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [5:0]       fncode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    muldiv_state_t      state_r, state_nxt_s;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               q_neg_r, r_neg_r, is_div_r, done_r;
    logic               busy_s, accept_s, signed_s, start_mul_s, start_div_s, div0_s, last_s;
    logic [WIDTH:0]     a_mag_s, b_mag_s, init_opnd_s;
    logic [2*WIDTH-1:0] init_acc_s, acc_s, prod_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

    // Magnitude in WIDTH+1 bits so the most negative value stays exact.
    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return -{1'b1, v};
        end else begin
            return {1'b0, v};
        end
    endfunction

    assign busy_s      = (state_r != IDLE);
    assign accept_s    = valid_i & ~busy_s & is_muldiv_fn(fncode);
    assign signed_s    = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    assign start_mul_s = accept_s & ((fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU));
    assign start_div_s = accept_s & ((fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU));
    assign div0_s      = (op_b == {WIDTH{1'b0}});
    assign a_mag_s     = mag(op_a, signed_s);
    assign b_mag_s     = mag(op_b, signed_s);

    // Datapath preload; divide-by-zero preloads the final {HI, LO} directly.
    always_comb begin
        init_acc_s  = {{WIDTH{1'b0}}, b_mag_s[WIDTH-1:0]};
        init_opnd_s = a_mag_s;
        if (start_div_s && div0_s) begin
            init_acc_s  = {op_a, {WIDTH{1'b1}}};
            init_opnd_s = b_mag_s;
        end else if (start_div_s) begin
            init_acc_s  = {{WIDTH{1'b0}}, a_mag_s[WIDTH-1:0]};
            init_opnd_s = b_mag_s;
        end else begin
            init_acc_s  = {{WIDTH{1'b0}}, b_mag_s[WIDTH-1:0]};
            init_opnd_s = a_mag_s;
        end
    end

    mips_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_mul_s | start_div_s),
        .step      ((state_r == MUL) || (state_r == DIV)),
        .div_mode  (state_r == DIV),
        .init_acc  (init_acc_s),
        .init_opnd (init_opnd_s),
        .acc       (acc_s),
        .last      (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_mul_s) begin
                    state_nxt_s = MUL;
                end else if (start_div_s) begin
                    state_nxt_s = div0_s ? FIX : DIV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL:     state_nxt_s = last_s ? FIX : MUL;
            DIV:     state_nxt_s = last_s ? FIX : DIV;
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Result sign correction applied in FIX.
    always_comb begin
        prod_s = q_neg_r ? -acc_s : acc_s;
        if (is_div_r) begin
            fix_lo_s = q_neg_r ? -acc_s[WIDTH-1:0] : acc_s[WIDTH-1:0];
            fix_hi_s = r_neg_r ? -acc_s[2*WIDTH-1:WIDTH] : acc_s[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo_s = prod_s[WIDTH-1:0];
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Operation kind and result signs latched at acceptance; zero divisor keeps raw values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            is_div_r <= 1'b0;
        end else if (start_mul_s || start_div_s) begin
            q_neg_r  <= signed_s & (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & ~(start_div_s & div0_s);
            r_neg_r  <= signed_s & op_a[WIDTH-1] & ~(start_div_s & div0_s);
            is_div_r <= start_div_s;
        end
    end

    // HI/LO and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == FIX);
            if (state_r == FIX) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else if (accept_s && (fncode == FUNCT_MTHI)) begin
                hi_r <= op_a;
            end else if (accept_s && (fncode == FUNCT_MTLO)) begin
                lo_r <= op_a;
            end
        end
    end

    // MFHI/MFLO read port.
    always_comb begin
        result_o = {WIDTH{1'b0}};
        if (valid_i && !busy_s) begin
            case (fncode)
                FUNCT_MFHI: result_o = hi_r;
                FUNCT_MFLO: result_o = lo_r;
                default:    result_o = {WIDTH{1'b0}};
            endcase
        end else begin
            result_o = {WIDTH{1'b0}};
        end
    end

    assign stall_o = valid_i & busy_s & is_muldiv_fn(fncode);
    assign busy_o  = busy_s;
    assign done_o  = done_r;
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected {HI,LO} queued at issue,
// compared whenever done_o pulses.
module tb_mips_muldiv;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [5:0]  fncode;
    logic [31:0] op_a, op_b;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o, hi_o, lo_o;

    int          n_tests;
    int          n_fail;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADDU = 6'h21;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .fncode   (fncode),
        .op_a     (op_a),
        .op_b     (op_b),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model for mult/div results as {HI, LO}.
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q, r;
        case (fn)
            F_MULT:  begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p; end
            F_MULTU: begin p = {32'd0, a} * {32'd0, b}; return p; end
            F_DIV:   begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q}; end
            F_DIVU:  begin q = a / b; r = a % b; return {r, q}; end
            default: return 64'd0;
        endcase
    endfunction

    // Scoreboard: every done_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_eq("hilo", {hi_o, lo_o}, mon_exp);
            end
        end
    end

    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat_lo, input int lat_hi,
                          input logic bg_v, input logic [5:0] bg_fn, input logic exp_stall);
        int k;
        bit seen;
        @(negedge clk);
        valid_i = 1'b1; fncode = fn; op_a = a; op_b = b;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        check_eq("busy_after_accept", {63'd0, busy_o}, 64'd1);
        @(negedge clk);
        valid_i = bg_v; fncode = bg_fn; op_a = 32'h0BAD_F00D; op_b = 32'h1357_9BDF;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (done_o) begin
                seen = 1'b1;
            end else if (k == 3 && bg_v) begin
                check_eq("bg_stall", {63'd0, stall_o}, {63'd0, exp_stall});
                check_eq("bg_result_busy", {32'd0, result_o}, 64'd0);
            end
        end
        if (!seen) begin
            check_eq("done_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("latency", 64'(k), 64'((k >= lat_lo && k <= lat_hi) ? k : lat_hi));
            check_eq("busy_in_done", {63'd0, busy_o}, 64'd0);
            if (bg_v && bg_fn == F_MFLO) check_eq("mflo_after_done", {32'd0, result_o}, {32'd0, exp[31:0]});
            if (bg_v && bg_fn == F_MFHI) check_eq("mfhi_after_done", {32'd0, result_o}, {32'd0, exp[63:32]});
        end
        valid_i = 1'b0;
    endtask

    task automatic issue1(input logic [5:0] fn, input logic [31:0] a);
        @(negedge clk);
        valid_i = 1'b1; fncode = fn; op_a = a; op_b = 32'd0;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] fn, input logic [31:0] exp);
        @(negedge clk);
        valid_i = 1'b1; fncode = fn;
        #1;
        check_eq(tag, {32'd0, result_o}, {32'd0, exp});
        valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  fns [4];
        logic [5:0]  fn;
        logic [31:0] a, b;
        n_tests = 0; n_fail = 0;
        fns[0] = F_MULT; fns[1] = F_MULTU; fns[2] = F_DIV; fns[3] = F_DIVU;
        rst_n = 1'b0; valid_i = 1'b0; fncode = 6'h00; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_hi", {32'd0, hi_o}, 64'd0);
        check_eq("rst_lo", {32'd0, lo_o}, 64'd0);
        check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("rst_done", {63'd0, done_o}, 64'd0);
        check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
        check_eq("rst_result", {32'd0, result_o}, 64'd0);
        rst_n = 1'b1;

        // MULT -3*5 with an MFLO waiting behind it
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 33, 33, 1'b1, F_MFLO, 1'b1);
        @(posedge clk); #1;
        check_eq("done_single_pulse", {63'd0, done_o}, 64'd0);

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 33, 33, 1'b1, F_MFHI, 1'b1);
        read_chk("mfhi_multu", F_MFHI, 32'hFFFF_FFFE);

        // back-to-back divides, including the signed overflow case
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, 1'b0, 6'h00, 1'b0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 33, 1'b0, 6'h00, 1'b0);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 33, 33, 1'b0, 6'h00, 1'b0);

        run_op(F_DIVU, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 1, 2, 1'b0, 6'h00, 1'b0);
        issue1(F_MTLO, 32'h1234_5678);
        check_eq("mtlo_lo", {32'd0, lo_o}, {32'd0, 32'h1234_5678});
        check_eq("mtlo_hi_kept", {32'd0, hi_o}, 64'd7);
        issue1(F_MTHI, 32'hCAFE_BABE);
        check_eq("mthi_hi", {32'd0, hi_o}, {32'd0, 32'hCAFE_BABE});
        check_eq("mthi_lo_kept", {32'd0, lo_o}, {32'd0, 32'h1234_5678});
        run_op(F_DIV, 32'h8000_0000, 32'd0, {32'h8000_0000, 32'hFFFF_FFFF}, 1, 2, 1'b0, 6'h00, 1'b0);

        // reset in the middle of a divide
        @(negedge clk);
        valid_i = 1'b1; fncode = F_DIVU; op_a = 32'd100; op_b = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("midrst_hi", {32'd0, hi_o}, 64'd0);
        check_eq("midrst_lo", {32'd0, lo_o}, 64'd0);
        check_eq("midrst_done", {63'd0, done_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        read_chk("mflo_after_rst", F_MFLO, 32'd0);

        // unrelated ALU op while busy
        run_op(F_DIVU, 32'd100, 32'd3, {32'd1, 32'd33}, 33, 33, 1'b1, F_ADDU, 1'b0);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 33, 1'b0, 6'h00, 1'b0);

        for (int i = 0; i < 6; i++) begin
            fn = fns[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
            if (fn == F_DIV || fn == F_DIVU) begin
                b = 32'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            end
            run_op(fn, a, b, model(fn, a, b), 33, 33, 1'b0, 6'h00, 1'b0);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits alongside the ALU in the EX stage and consumes the 6-bit function code from the ALU control stage.
- Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Raises a stall to the pipeline while an iterative operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  EX-stage instruction is valid and not being flushed.
- fncode  input  6  function code from ALU control.
- op_a  input  WIDTH  rs value (dividend, multiplicand, MT source).
- op_b  input  WIDTH  rt value (divisor, multiplier).
- stall_o  output  1  pipeline must hold EX and earlier stages this cycle.
- busy_o  output  1  iterative operation in progress.
- done_o  output  1  one-cycle pulse when HI/LO take a mult/div result.
- result_o  output  WIDTH  MFHI/MFLO read data; 0 otherwise.
- hi_o  output  WIDTH  current HI.
- lo_o  output  WIDTH  current LO.

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, state=IDLE, and all internal accumulators/counters cleared. Outputs during and after reset: busy_o=0, done_o=0, stall_o=0, result_o=0. Reset mid-operation abandons the operation; HI/LO do not take partial results.
- A request is valid_i=1 with fncode in {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13}. Any other fncode is ignored: no stall, result_o=0.
- stall_o = valid_i & busy_o & (fncode is any muldiv/HI/LO code). It is combinational.
- A stalled request is not accepted. It is re-presented unchanged and accepted in the first cycle busy_o=0.
- MFHI/MFLO:
  - result_o = HI/LO combinationally when valid_i=1 and not busy.
  - In the cycle after done_o, result_o returns the new value.
- MTHI/MTLO: HI/LO = op_a at the accepting edge. Latency 1. Does not touch the other register.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: on accepting MULT/MULTU go to MUL; on accepting DIV/DIVU go to DIV. Latch |op_a|, |op_b| (signed ops) or raw values (unsigned ops), plus the result signs. Counter = 0.
  - MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator. After WIDTH cycles go to FIX.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH cycles go to FIX.
  - FIX: apply sign correction and write HI/LO, then return to IDLE.
    - Signed product is negated if sign(a)^sign(b).
    - Quotient sign is sign(a)^sign(b); remainder sign is sign(a).
- Timing: acceptance edge E0; busy_o=1 from after E0 through the cycle before E(WIDTH+1). HI/LO are written at E(WIDTH+1), so total latency is 33 cycles at WIDTH=32. done_o=1 for exactly the cycle after E(WIDTH+1), and busy_o=0 in that cycle.
- Boundary cases:
  - Divide by zero: skip iteration, go directly to FIX; LO=all ones, HI=op_a. Latency 2.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
  - Signed magnitudes use WIDTH+1-bit internal values so that |0x80000000| is correct.
- Back-to-back: a new mult/div may be accepted in the same cycle done_o=1.
- HI/LO never change except at the MT accepting edge, the FIX edge, or reset.

Decomposition:
- Shared package: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, alongside the existing FUNCT_* constants, plus a muldiv_state_t enum (IDLE, MUL, DIV, FIX).
- One natural sub-module: muldiv_datapath, holding the iteration registers and the shift-add/restoring step. The FSM and HI/LO stay in the top module.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> stall_o=1 on a following MFLO until done. At E33: HI=0xFFFFFFFF, LO=0xFFFFFFF1; done_o pulses once.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MFHI then returns 0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 7/0 -> done after 2 cycles, LO=0xFFFFFFFF, HI=7. Then MTLO 0x12345678 -> LO=0x12345678, HI unchanged at 7.
- Start DIVU 100/3 and assert rst_n=0 at cycle 10 -> busy_o=0 immediately, HI=LO=0, no done_o. After release, MFLO returns 0.
- Non-muldiv fncode (ADDU 0x21) with valid_i=1 while busy -> stall_o=0, result_o=0, operation completes normally.
